// File: rtl/mnist_pkg.sv
// Shared constants and the loader state encoding for the MNIST frame loader.
package mnist_pkg;

    localparam int NPIX  = 64;
    localparam int LANES = 4;
    localparam int BEATS = NPIX / LANES;
    localparam int PIX_W = 2;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

endpackage

// File: rtl/mnist_frame_buffer.sv
// Quantized pixel store: 2-bit writes by pixel index, combinational
// LANES-wide reads by beat index (pixel i lives in beat i/LANES, lane i%LANES).
module mnist_frame_buffer
    import mnist_pkg::*;
#(
    parameter int NPIX_P  = NPIX,
    parameter int LANES_P = LANES,
    parameter int CW      = $clog2(NPIX_P),
    parameter int BW      = $clog2(NPIX_P / LANES_P)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [CW-1:0]              wr_idx,
    input  logic [PIX_W-1:0]           wr_data,
    input  logic [BW-1:0]              rd_beat,
    output logic [LANES_P*PIX_W-1:0]   rd_data
);

    localparam int LW = $clog2(LANES_P);

    // Contents are never reset; the loader only streams after a full refill.
    logic [PIX_W-1:0] mem_q [NPIX_P];
    logic [CW-1:0]    base;

    // Write one quantized pixel per accepted beat of upstream data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Gather the LANES pixels of the addressed beat, lane k at bits [2k+1:2k].
    always_comb begin
        base    = CW'(rd_beat) << LW;
        rd_data = '0;
        for (int k = 0; k < LANES_P; k++) begin
            rd_data[k*PIX_W +: PIX_W] = mem_q[base | CW'(k)];
        end
    end

endmodule

// File: rtl/mnist_frame_loader.sv
// Collects a frame of 8-bit pixels, quantizes them to 2 bits, streams the
// frame to the MNIST core as LANES-wide beats, then waits for (or times out
// on) the core's prediction and holds it until downstream takes it.
module mnist_frame_loader
    import mnist_pkg::*;
#(
    parameter int NPIX    = mnist_pkg::NPIX,
    parameter int LANES   = mnist_pkg::LANES,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic [7:0]               pix_data,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    output logic                     core_start,
    output logic [LANES*PIX_W-1:0]   core_pixels,
    input  logic                     core_done,
    input  logic [3:0]               core_prediction,
    output logic                     result_valid,
    output logic [3:0]               result_class,
    output logic                     result_err,
    input  logic                     result_ready
);

    localparam int BEATS_L = NPIX / LANES;
    localparam int CW      = $clog2(NPIX);
    localparam int BW      = $clog2(BEATS_L);
    localparam int TW      = $clog2(TIMEOUT);

    localparam logic [CW-1:0] CNT_LAST  = CW'(NPIX - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_L - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [3:0]               cls_q, cls_d;
    logic                     err_q, err_d;

    logic                     wr_en;
    logic [CW-1:0]            wr_idx;
    logic [LANES*PIX_W-1:0]   rd_data;

    // Nothing is written while reset is held, even though pix_ready reads 1.
    mnist_frame_buffer #(
        .NPIX_P  (NPIX),
        .LANES_P (LANES)
    ) u_buf (
        .clk     (clk),
        .we      (wr_en & ~rst),
        .wr_idx  (wr_idx),
        .wr_data (pix_data[7:6]),
        .rd_beat (beat_q),
        .rd_data (rd_data)
    );

    // State, counters and captured result, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            cls_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode; stream outputs are gated by state so a
    // reset drops them to zero immediately.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;
        cls_d        = cls_q;
        err_d        = err_q;
        wr_en        = 1'b0;
        wr_idx       = cnt_q;
        pix_ready    = 1'b0;
        core_start   = 1'b0;
        core_pixels  = '0;
        result_valid = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        // A new frame restarts at pixel 0, dropping any partial fill.
                        wr_idx = '0;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STREAM;
                        cnt_d   = '0;
                        beat_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_STREAM: begin
                core_pixels = rd_data;
                core_start  = (beat_q == '0);
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_WAIT;
                    beat_d  = '0;
                    tmo_d   = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_RESULT;
                    cls_d   = core_prediction;
                    err_d   = (core_prediction > 4'd9);
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RESULT;
                    cls_d   = 4'hF;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign result_class = cls_q;
    assign result_err   = err_q;

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Directed bench for mnist_frame_loader: drives and samples on the falling
// clock edge, checks each point with an immediate assertion.
module tb_mnist_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_sof;
    logic       pix_ready;
    logic       core_start;
    logic [7:0] core_pixels;
    logic       core_done;
    logic [3:0] core_prediction;
    logic       result_valid;
    logic [3:0] result_class;
    logic       result_err;
    logic       result_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mnist_frame_loader dut (
        .clk             (clk),
        .rst             (rst),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_sof         (pix_sof),
        .pix_ready       (pix_ready),
        .core_start      (core_start),
        .core_pixels     (core_pixels),
        .core_done       (core_done),
        .core_prediction (core_prediction),
        .result_valid    (result_valid),
        .result_class    (result_class),
        .result_err      (result_err),
        .result_ready    (result_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: 8'hC0 on lane 3, 8'h40 elsewhere; mode 1: 8'hFF;
    // mode 2: 8'h80 with a core_done pulse on pixel 5.
    task automatic feed(input int n, input int mode, input bit first_sof);
        chk("fill_ready", 32'(pix_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_sof   = first_sof && (i == 0);
            core_done = (mode == 2) && (i == 5);
            if (mode == 0)      pix_data = ((i % 4) == 3) ? 8'hC0 : 8'h40;
            else if (mode == 1) pix_data = 8'hFF;
            else                pix_data = 8'h80;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        core_done = 1'b0;
    endtask

    // Called on the first STREAM cycle; leaves the bench in the first WAIT cycle.
    task automatic stream_chk(input logic [7:0] exp_byte);
        for (int b = 0; b < 16; b++) begin
            chk("beat_pixels", 32'(core_pixels), 32'(exp_byte));
            chk("beat_start", 32'(core_start), 32'(b == 0));
            chk("beat_ready", 32'(pix_ready), 32'd0);
            core_done = (b == 3);
            @(negedge clk);
        end
        core_done = 1'b0;
        chk("wait_pixels", 32'(core_pixels), 32'd0);
        chk("wait_start", 32'(core_start), 32'd0);
        chk("wait_valid", 32'(result_valid), 32'd0);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("hs_valid", 32'(result_valid), 32'd0);
        chk("hs_ready", 32'(pix_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        pix_valid = 1'b1;
        pix_data = 8'hFF;
        pix_sof = 1'b0;
        core_done = 1'b0;
        core_prediction = 4'd0;
        result_ready = 1'b0;

        // Reset state, with pixels offered during reset
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(pix_ready), 32'd1);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_class", 32'(result_class), 32'd0);
        chk("rst_err", 32'(result_err), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_pixels", 32'(core_pixels), 32'd0);
        pix_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Frame A, prediction 7 after 100 WAIT cycles, hold for 10 cycles
        feed(64, 0, 1'b1);
        stream_chk(8'hD5);
        repeat (100) @(negedge clk);
        chk("wait100_valid", 32'(result_valid), 32'd0);
        core_prediction = 4'd7;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_prediction = 4'd0;
        for (int c = 0; c < 10; c++) begin
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_class", 32'(result_class), 32'd7);
            chk("hold_err", 32'(result_err), 32'd0);
            @(negedge clk);
        end
        handshake();

        // Partial frame with ignored core_done, then sof restart with 8'hFF
        feed(30, 2, 1'b0);
        chk("fill_done_ignored", 32'(result_valid), 32'd0);
        chk("partial_ready", 32'(pix_ready), 32'd1);
        feed(64, 1, 1'b1);
        stream_chk(8'hFF);

        // Timeout: RESULT after exactly 4096 WAIT cycles
        repeat (4095) @(negedge clk);
        chk("tmo_last_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("tmo_valid", 32'(result_valid), 32'd1);
        chk("tmo_class", 32'(result_class), 32'hF);
        chk("tmo_err", 32'(result_err), 32'd1);
        handshake();

        // Out-of-range class
        feed(64, 0, 1'b0);
        stream_chk(8'hD5);
        core_prediction = 4'd12;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("oor_valid", 32'(result_valid), 32'd1);
        chk("oor_class", 32'(result_class), 32'd12);
        chk("oor_err", 32'(result_err), 32'd1);
        handshake();

        // Reset during STREAM beat 5
        feed(64, 0, 1'b1);
        repeat (5) @(negedge clk);
        chk("b5_pixels", 32'(core_pixels), 32'hD5);
        rst = 1'b1;
        #1;
        chk("rst_s_pixels", 32'(core_pixels), 32'd0);
        chk("rst_s_start", 32'(core_start), 32'd0);
        chk("rst_s_ready", 32'(pix_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh frame after that reset, then reset during WAIT
        feed(64, 1, 1'b1);
        stream_chk(8'hFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_w_ready", 32'(pix_ready), 32'd1);
        chk("rst_w_valid", 32'(result_valid), 32'd0);
        chk("rst_w_pixels", 32'(core_pixels), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Recovery frame
        feed(64, 0, 1'b0);
        stream_chk(8'hD5);
        core_prediction = 4'd3;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("rec_class", 32'(result_class), 32'd3);
        chk("rec_err", 32'(result_err), 32'd0);
        chk("rec_valid", 32'(result_valid), 32'd1);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
